// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulate stage: product width, FSM states
// and default accumulator/counter widths.
package mac_pkg;

    localparam int unsigned PROD_W    = 16;
    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/mac_acc_add.sv
// Combinational extend + add + overflow detect for the accumulator.
// Saturating arithmetic replaces wrap-around when MAC_ACC_SATURATE_EN is defined.
module mac_acc_add
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W       = ACC_W_DEF,
    parameter int          PROD_SIGNED = 0
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] product_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] raw;
    logic             ovf;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        ext   = '0;
        wide  = '0;
        raw   = '0;
        ovf   = 1'b0;
        sum_o = '0;
        ovf_o = 1'b0;

        if (PROD_SIGNED != 0) begin
            ext = {{(ACC_W-PROD_W){product_i[PROD_W-1]}}, product_i};
        end else begin
            ext = {{(ACC_W-PROD_W){1'b0}}, product_i};
        end

        wide = {1'b0, acc_i} + {1'b0, ext};
        raw  = wide[ACC_W-1:0];

        // Signed overflow: operands agree in sign but the result does not.
        if (PROD_SIGNED != 0) begin
            ovf = (acc_i[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc_i[ACC_W-1]);
        end else begin
            ovf = wide[ACC_W];
        end

        sum_o = raw;
`ifdef MAC_ACC_SATURATE_EN
        if (ovf) begin
            if (PROD_SIGNED != 0) begin
                sum_o = acc_i[ACC_W-1] ? S_MIN : S_MAX;
            end else begin
                sum_o = U_MAX;
            end
        end
`else
        // Wrap-around: the raw modulo sum is kept; clamp constants unused.
        if (1'b0) begin
            sum_o = U_MAX & S_MAX & S_MIN;
        end
`endif
        ovf_o = ovf;
    end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulate stage after the 8x8 multiplier: product register, ACC_W-bit
// accumulator, term counter, sticky overflow, valid/ready result (MAC_ACC_SATURATE_EN).
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W       = ACC_W_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int          PROD_SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    acc_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              s1_full_q, s1_full_d;
    logic [PROD_W-1:0] s1_prod_q, s1_prod_d;
    logic              s1_last_q, s1_last_d;

    logic              capture;
    logic              add_fire;
    logic              out_fire;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;

    mac_acc_add #(
        .ACC_W       (ACC_W),
        .PROD_SIGNED (PROD_SIGNED)
    ) u_add (
        .acc_i     (acc_q),
        .product_i (s1_prod_q),
        .sum_o     (add_sum),
        .ovf_o     (add_ovf)
    );

    // Stage 1 may refill while stage 2 drains it, so only a held term in DONE stalls.
    assign in_ready  = !s1_full_q || (state_q != DONE);
    assign capture   = in_valid && in_ready;
    assign add_fire  = s1_full_q && (state_q != DONE);
    assign out_fire  = (state_q == DONE) && out_ready;

    assign out_valid = (state_q == DONE);
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;
    assign busy      = (state_q != IDLE) || s1_full_q;

    always_comb begin
        s1_full_d = s1_full_q;
        s1_prod_d = s1_prod_q;
        s1_last_d = s1_last_q;

        if (clear) begin
            s1_full_d = 1'b0;
        end else if (capture) begin
            s1_full_d = 1'b1;
            s1_prod_d = in_product;
            s1_last_d = in_last;
        end else if (add_fire) begin
            s1_full_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (out_fire) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end

        if (add_fire) begin
            acc_d   = add_sum;
            count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
            ovf_d   = ovf_q | add_ovf;
            state_d = s1_last_q ? DONE : ACCUM;
        end

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            s1_full_q <= 1'b0;
            s1_prod_q <= '0;
            s1_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            s1_full_q <= s1_full_d;
            s1_prod_q <= s1_prod_d;
            s1_last_q <= s1_last_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench: unsigned and signed instances share stimulus; a
// transaction-level dot-product model scores every valid result cycle.
module tb_mac_accumulator;

    localparam int ACC_W = 24;
    localparam int CNT_W = 8;
    localparam longint U_MAX = (64'sd1 <<< ACC_W) - 1;
    localparam longint S_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint S_MIN = -(64'sd1 <<< (ACC_W - 1));
    localparam longint MODV  = 64'sd1 <<< ACC_W;
`ifdef MAC_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } res_t;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic [15:0]       in_product;
    logic              in_last;
    logic              out_ready;

    logic              u_in_ready, u_out_valid, u_out_ovf, u_busy;
    logic [ACC_W-1:0]  u_out_acc;
    logic [CNT_W-1:0]  u_out_count;
    logic              s_in_ready, s_out_valid, s_out_ovf, s_busy;
    logic [ACC_W-1:0]  s_out_acc;
    logic [CNT_W-1:0]  s_out_count;

    int n_checks = 0;
    int n_fail   = 0;

    res_t   exp_q0[$];
    res_t   exp_q1[$];
    longint part_acc [2];
    int     part_cnt [2];
    bit     part_ovf [2];

    mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W), .PROD_SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(u_in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(u_out_valid), .out_ready(out_ready), .out_acc(u_out_acc),
        .out_count(u_out_count), .out_ovf(u_out_ovf), .busy(u_busy)
    );

    mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W), .PROD_SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
        .out_count(s_out_count), .out_ovf(s_out_ovf), .busy(s_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_flush();
        exp_q0.delete();
        exp_q1.delete();
        for (int d = 0; d < 2; d++) begin
            part_acc[d] = 0;
            part_cnt[d] = 0;
            part_ovf[d] = 1'b0;
        end
    endtask

    // Adds one term to the running dot product of instance d (0 unsigned, 1 signed).
    task automatic model_term(input int d, input logic [15:0] p, input bit last);
        longint ext;
        longint s;
        res_t   r;
        ext = longint'(p);
        if (d == 1 && p[15]) ext = ext - 65536;
        s = part_acc[d] + ext;
        if (d == 0) begin
            if (s > U_MAX) begin
                part_ovf[d] = 1'b1;
                s = SAT ? U_MAX : s - MODV;
            end
        end else begin
            if (s > S_MAX) begin
                part_ovf[d] = 1'b1;
                s = SAT ? S_MAX : s - MODV;
            end else if (s < S_MIN) begin
                part_ovf[d] = 1'b1;
                s = SAT ? S_MIN : s + MODV;
            end
        end
        part_acc[d] = s;
        if (part_cnt[d] < 255) part_cnt[d]++;
        if (last) begin
            r.acc = s[ACC_W-1:0];
            r.cnt = part_cnt[d][CNT_W-1:0];
            r.ovf = part_ovf[d];
            if (d == 0) exp_q0.push_back(r);
            else        exp_q1.push_back(r);
            part_acc[d] = 0;
            part_cnt[d] = 0;
            part_ovf[d] = 1'b0;
        end
    endtask

    // Compare process: inputs change #1 after posedge, so negedge sees settled values.
    always @(negedge clk) begin
        if (rst) begin
            model_flush();
        end else begin
            if (u_out_valid) begin
                if (exp_q0.size() == 0) check("u_unexpected_result", 1, 0);
                else begin
                    check("u_out_acc",   u_out_acc,   exp_q0[0].acc);
                    check("u_out_count", u_out_count, exp_q0[0].cnt);
                    check("u_out_ovf",   u_out_ovf,   exp_q0[0].ovf);
                    if (out_ready) void'(exp_q0.pop_front());
                end
            end
            if (s_out_valid) begin
                if (exp_q1.size() == 0) check("s_unexpected_result", 1, 0);
                else begin
                    check("s_out_acc",   s_out_acc,   exp_q1[0].acc);
                    check("s_out_count", s_out_count, exp_q1[0].cnt);
                    check("s_out_ovf",   s_out_ovf,   exp_q1[0].ovf);
                    if (out_ready) void'(exp_q1.pop_front());
                end
            end
            if (clear) begin
                model_flush();
            end else if (in_valid) begin
                if (u_in_ready) model_term(0, in_product, in_last);
                if (s_in_ready) model_term(1, in_product, in_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] p, input bit last);
        bit took;
        took = 1'b0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        for (int i = 0; i < 50 && !took; i++) begin
            @(negedge clk);
            took = u_in_ready;
            tick();
        end
        if (!took) check("send_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int caps;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;
        model_flush();
        repeat (3) tick();

        check("rst_out_valid", u_out_valid, 0);
        check("rst_out_acc",   u_out_acc,   0);
        check("rst_out_count", u_out_count, 0);
        check("rst_out_ovf",   u_out_ovf,   0);
        check("rst_busy",      u_busy,      0);
        check("rst_in_ready",  u_in_ready,  1);
        rst = 1'b0;
        tick();

        // Unsigned basic: 3 + 5 + 7
        send(16'd3, 1'b0);
        send(16'd5, 1'b0);
        send(16'd7, 1'b1);
        check("basic_valid_early", u_out_valid, 0);
        tick();
        check("basic_valid",  u_out_valid, 1);
        check("basic_acc",    u_out_acc,   15);
        check("basic_count",  u_out_count, 3);
        check("basic_ovf",    u_out_ovf,   0);
        check("basic_s_acc",  s_out_acc,   15);
        tick();
        check("basic_idle_valid", u_out_valid, 0);
        check("basic_idle_busy",  u_busy,      0);

        // Signed extension: 0x8000 + 0x0010
        send(16'h8000, 1'b0);
        send(16'h0010, 1'b1);
        tick();
        check("signed_acc",   s_out_acc, 24'hFF8010);
        check("signed_ovf",   s_out_ovf, 0);
        check("unsigned_acc", u_out_acc, 24'h008010);
        tick();

        // Overflow: 259 terms of 65025
        for (int i = 0; i < 258; i++) send(16'd65025, 1'b0);
        send(16'd65025, 1'b1);
        tick();
        check("ovf_valid", u_out_valid, 1);
        check("ovf_acc",   u_out_acc,   SAT ? 64'd16777215 : 64'd64259);
        check("ovf_count", u_out_count, 255);
        check("ovf_flag",  u_out_ovf,   1);
        check("ovf_s_acc", s_out_acc,   24'hFDFB03);
        check("ovf_s_flag", s_out_ovf,  0);
        tick();

        // Backpressure: result held 10 cycles while input keeps offering
        out_ready = 1'b0;
        send(16'd1, 1'b0);
        send(16'd2, 1'b1);
        tick();
        check("bp_valid", u_out_valid, 1);
        in_valid = 1'b1; in_product = 16'd40; in_last = 1'b0;
        caps = 0;
        repeat (10) begin
            @(negedge clk);
            if (u_in_ready) caps++;
            tick();
            check("bp_acc_stable", u_out_acc, 3);
        end
        check("bp_captures", caps, 1);
        check("bp_in_ready", u_in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_released", u_out_valid, 0);
        check("bp_busy_held", u_busy, 1);
        tick();
        check("bp_new_count", u_out_count, 1);
        check("bp_new_acc",   u_out_acc,   40);
        send(16'd0, 1'b1);
        repeat (2) tick();

        // clear mid-stream with a simultaneous offer
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_product = 16'd50; in_last = 1'b0;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_acc",   u_out_acc,   0);
        check("clr_count", u_out_count, 0);
        check("clr_busy",  u_busy,      0);
        check("clr_valid", u_out_valid, 0);
        send(16'd9, 1'b1);
        tick();
        check("clr_after_acc",   u_out_acc,   9);
        check("clr_after_count", u_out_count, 1);
        tick();

        // Asynchronous reset while holding a result
        out_ready = 1'b0;
        send(16'd5, 1'b1);
        tick();
        check("arst_pre_valid", u_out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid",    u_out_valid, 0);
        check("arst_acc",      u_out_acc,   0);
        check("arst_busy",     u_busy,      0);
        check("arst_in_ready", u_in_ready,  1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("arst_after_valid", u_out_valid, 0);

        check("u_results_drained", exp_q0.size(), 0);
        check("s_results_drained", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
